// File: rtl/axis_out_packer.sv
// axis_out_packer
//   Requantizes the accelerator's signed WORD_WIDTH_ACC accumulator stream to
//   signed WORD_WIDTH words (round-half-up arithmetic right shift followed by
//   saturation). Packs BEATS input beats into one M_DATA_WIDTH output beat and
//   restarts packing at slot 0 after every tlast. Counts completed packets.
//
//   Ports
//     aclk, aresetn        clock, synchronous active-low reset
//     cfg_shift            right-shift amount, latched on the first beat of a packet
//     s_axis_*             input stream (tdata word 0 at LSB, one tkeep bit per word)
//     m_axis_*             packed output stream (one tkeep bit per output word)
//     pkt_count            completed output packets, wraps
//
//   Build option
//     OUT_PACKER_RELU_EN   when defined, negative quantized words are forced to 0
module axis_out_packer #(
  parameter int WORD_WIDTH_ACC = 32,
  parameter int WORD_WIDTH     = 8,
  parameter int S_DATA_WIDTH   = 64,
  parameter int M_DATA_WIDTH   = 64,
  parameter int SHIFT_BITS     = 5,
  parameter int CNT_BITS       = 16
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [SHIFT_BITS-1:0]                  cfg_shift,
  output logic                                   s_axis_tready,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  input  logic [S_DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [S_DATA_WIDTH/WORD_WIDTH_ACC-1:0] s_axis_tkeep,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  output logic [M_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [M_DATA_WIDTH/WORD_WIDTH-1:0]     m_axis_tkeep,
  output logic [CNT_BITS-1:0]                    pkt_count
);

  localparam int S_WORDS = S_DATA_WIDTH / WORD_WIDTH_ACC;
  localparam int M_WORDS = M_DATA_WIDTH / WORD_WIDTH;
  localparam int BEATS   = M_WORDS / S_WORDS;
  localparam int Q_WIDTH = S_WORDS * WORD_WIDTH;
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);

  // Saturation bounds and the rounding seed, all in WORD_WIDTH_ACC+1 bits.
  localparam logic signed [WORD_WIDTH_ACC:0] SAT_MAX =
    $signed({{(WORD_WIDTH_ACC-WORD_WIDTH+2){1'b0}}, {(WORD_WIDTH-1){1'b1}}});
  localparam logic signed [WORD_WIDTH_ACC:0] SAT_MIN =
    $signed({{(WORD_WIDTH_ACC-WORD_WIDTH+2){1'b1}}, {(WORD_WIDTH-1){1'b0}}});
  localparam logic [WORD_WIDTH-1:0] SAT_MAX_W = {1'b0, {(WORD_WIDTH-1){1'b1}}};
  localparam logic [WORD_WIDTH-1:0] SAT_MIN_W = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic [WORD_WIDTH_ACC:0] RND_ONE = {{WORD_WIDTH_ACC{1'b0}}, 1'b1};

  // Shift capture
  logic                  first_beat;
  logic [SHIFT_BITS-1:0] shift_hold;
  logic [SHIFT_BITS-1:0] shift_eff;

  // Stage Q
  logic                 q_valid;
  logic                 q_last;
  logic [Q_WIDTH-1:0]   q_data;
  logic [S_WORDS-1:0]   q_keep;
  logic [Q_WIDTH-1:0]   quant_data;

  logic signed [WORD_WIDTH_ACC:0] ext;
  logic signed [WORD_WIDTH_ACC:0] rnd;
  logic signed [WORD_WIDTH_ACC:0] sum;
  logic signed [WORD_WIDTH_ACC:0] shr;
  logic [WORD_WIDTH-1:0]          word;

  // Stage P
  logic [IDX_W-1:0]        idx;
  logic [M_DATA_WIDTH-1:0] acc_data;
  logic [M_WORDS-1:0]      acc_keep;
  logic [M_DATA_WIDTH-1:0] merged_data;
  logic [M_WORDS-1:0]      merged_keep;

  logic s_hs;
  logic m_hs;
  logic completing;
  logic q_adv;

  // The first beat of a packet uses the live cfg_shift; later beats use the
  // value captured with that first beat.
  assign shift_eff = first_beat ? cfg_shift : shift_hold;

  always_comb begin
    quant_data = '0;
    ext        = '0;
    rnd        = '0;
    sum        = '0;
    shr        = '0;
    word       = '0;
    for (int unsigned w = 0; w < S_WORDS; w++) begin
      ext = $signed({s_axis_tdata[w*WORD_WIDTH_ACC + WORD_WIDTH_ACC - 1],
                     s_axis_tdata[w*WORD_WIDTH_ACC +: WORD_WIDTH_ACC]});
      // 2^(shift-1) for shift>0, 0 for shift==0
      rnd = $signed((RND_ONE << shift_eff) >> 1);
      sum = ext + rnd;
      shr = sum >>> shift_eff;
      if (shr > SAT_MAX) begin
        word = SAT_MAX_W;
      end else if (shr < SAT_MIN) begin
        word = SAT_MIN_W;
      end else begin
        word = shr[WORD_WIDTH-1:0];
      end
`ifdef OUT_PACKER_RELU_EN
      if (word[WORD_WIDTH-1]) begin
        word = '0;
      end
`endif
      // Unkept words are zeroed here so unwritten output slots read as 0.
      if (!s_axis_tkeep[w]) begin
        word = '0;
      end
      quant_data[w*WORD_WIDTH +: WORD_WIDTH] = word;
    end
  end

  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (idx == IDX_W'(b)) begin
        merged_data[b*Q_WIDTH +: Q_WIDTH] = q_data;
        merged_keep[b*S_WORDS +: S_WORDS] = q_keep;
      end
    end
  end

  assign completing    = (idx == IDX_LAST) | q_last;
  assign q_adv         = q_valid & (~completing | ~m_axis_tvalid | m_axis_tready);
  assign s_axis_tready = ~q_valid | q_adv;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      first_beat    <= 1'b1;
      shift_hold    <= '0;
      q_valid       <= 1'b0;
      q_last        <= 1'b0;
      q_data        <= '0;
      q_keep        <= '0;
      idx           <= '0;
      acc_data      <= '0;
      acc_keep      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      pkt_count     <= '0;
    end else begin
      if (s_hs) begin
        q_data     <= quant_data;
        q_keep     <= s_axis_tkeep;
        q_last     <= s_axis_tlast;
        q_valid    <= 1'b1;
        first_beat <= s_axis_tlast;
        if (first_beat) begin
          shift_hold <= cfg_shift;
        end
      end else if (q_adv) begin
        q_valid <= 1'b0;
      end

      if (q_adv) begin
        if (completing) begin
          m_axis_tdata <= merged_data;
          m_axis_tkeep <= merged_keep;
          m_axis_tlast <= q_last;
          acc_data     <= '0;
          acc_keep     <= '0;
          idx          <= '0;
        end else begin
          acc_data <= merged_data;
          acc_keep <= merged_keep;
          idx      <= idx + 1'b1;
        end
      end

      if (q_adv && completing) begin
        m_axis_tvalid <= 1'b1;
      end else if (m_hs) begin
        m_axis_tvalid <= 1'b0;
      end

      if (m_hs && m_axis_tlast) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_out_packer.sv
// Self-checking bench for axis_out_packer (default parameters).
`timescale 1ns/1ps
module tb_axis_out_packer;

  localparam int M_WORDS = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        s_axis_tready;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [1:0]  s_axis_tkeep = '0;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic [15:0] pkt_count;

  always #5 aclk = ~aclk;

  axis_out_packer #(
    .WORD_WIDTH_ACC(32),
    .WORD_WIDTH    (8),
    .S_DATA_WIDTH  (64),
    .M_DATA_WIDTH  (64),
    .SHIFT_BITS    (5),
    .CNT_BITS      (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_shift    (cfg_shift),
    .s_axis_tready(s_axis_tready),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .pkt_count    (pkt_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned model_pkts = 0;
  int unsigned in_hs = 0;
  int          ready_mode = 1;  // 0 low, 1 high, 2 random
  bit          bp_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference requantizer: plain integer arithmetic on a 64-bit value.
  function automatic logic [7:0] q_ref(input logic [31:0] x, input int sh);
    longint v;
    v = longint'($signed(x));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`ifdef OUT_PACKER_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[7:0];
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic [7:0] k, input logic l);
    exp_t e;
    e.data = d; e.keep = k; e.last = l;
    exp_q.push_back(e);
  endtask

  // A packet's words, quantized, fill output beats 8 at a time.
  task automatic model_push(input logic [31:0] w[$], input int sh);
    exp_t e;
    int unsigned n = w.size();
    for (int unsigned base = 0; base < n; base += M_WORDS) begin
      e.data = '0; e.keep = '0;
      for (int unsigned j = 0; j < M_WORDS && base + j < n; j++) begin
        e.data[j*8 +: 8] = q_ref(w[base+j], sh);
        e.keep[j] = 1'b1;
      end
      e.last = (base + M_WORDS >= n);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [31:0] gen_word();
    int v;
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: begin v = int'($urandom_range(0, 4000)) - 2000; return 32'(v); end
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  // m_axis_tready driver, applied 2ns after each rising edge.
  always @(posedge aclk) begin
    #2;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [8:0]  prev_ctl;
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      prev_stall = 1'b0;
      model_pkts = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_ctl", 64'({m_axis_tkeep, m_axis_tlast}), 64'(prev_ctl));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("pkt_count", 64'(pkt_count), 64'(model_pkts % 65536));
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.data);
          check("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
          check("tlast", 64'(m_axis_tlast), 64'(e.last));
        end
        if (m_axis_tlast) model_pkts++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_ctl   = {m_axis_tkeep, m_axis_tlast};
      if (s_axis_tvalid && s_axis_tready) in_hs++;
    end
  end

  // Called and returns 1ns after a rising edge; the beat is accepted on the
  // rising edge just before return.
  task automatic send_beat(input logic [63:0] d, input logic [1:0] k, input logic l);
    int unsigned n = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_tready) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // cfg_shift is scrambled on every beat after the first to show it is ignored.
  task automatic send_words(input logic [31:0] w[$], input int sh, input bit gaps);
    int unsigned n  = w.size();
    int unsigned nb = (n + 1) / 2;
    logic [31:0] hi;
    for (int unsigned b = 0; b < nb; b++) begin
      hi = (2*b + 1 < n) ? w[2*b+1] : $urandom;
      cfg_shift = (b == 0) ? 5'(sh) : 5'($urandom_range(0, 31));
      send_beat({hi, w[2*b]}, (2*b + 1 < n) ? 2'b11 : 2'b01, b == nb - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    @(posedge aclk);
    #1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 2000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size() == 0), 64'd1);
  endtask

  initial begin
    logic [31:0] w[$];
    int unsigned base;
    int unsigned n;
    int          sh;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_last", 64'(m_axis_tlast), 64'd0);
    check("rst_m_data", m_axis_tdata, 64'd0);
    check("rst_m_keep", 64'(m_axis_tkeep), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_s_ready", 64'(s_axis_tready), 64'd1);
    @(posedge aclk);
    #1;

    // 0x10..0x80 >> 4 with latency check
    w = {32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
    push_exp(64'h0807060504030201, 8'hFF, 1'b1);
    send_words(w, 4, 0);
    @(negedge aclk);
    check("latency_t1", 64'(m_axis_tvalid), 64'd0);
    @(negedge aclk);
    check("latency_t2", 64'(m_axis_tvalid), 64'd1);
    wait_drain();
    check("pkt_count_1", 64'(pkt_count), 64'd1);

    // saturation, rounding, sign
`ifdef OUT_PACKER_RELU_EN
    push_exp(64'h007F, 8'h03, 1'b1);
    push_exp(64'h0002, 8'h03, 1'b1);
    push_exp(64'h0500, 8'h03, 1'b1);
`else
    push_exp(64'h807F, 8'h03, 1'b1);
    push_exp(64'hFF02, 8'h03, 1'b1);
    push_exp(64'h05FB, 8'h03, 1'b1);
`endif
    w = {32'h7FFF_FFFF, 32'h8000_0000};
    send_words(w, 0, 0);
    w = {32'd24, 32'hFFFF_FFE8};
    send_words(w, 4, 0);
    w = {32'hFFFF_FFFB, 32'd5};
    send_words(w, 0, 0);
    wait_drain();

    // short packet, then the next one restarts at slot 0
    push_exp(64'h0000_0005_0403_0201, 8'h1F, 1'b1);
    push_exp(64'h2211, 8'h03, 1'b1);
    w = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    send_words(w, 0, 0);
    w = {32'h11, 32'h22};
    send_words(w, 0, 0);
    wait_drain();

    // backpressure: 2*BEATS beats absorbed, then ready drops
    ready_mode = 0;
    base = in_hs;
    w = {};
    for (int i = 0; i < 32; i++) w.push_back(gen_word());
    sh = $urandom_range(0, 31);
    model_push(w, sh);
    fork
      begin
        send_words(w, sh, 0);
        bp_done = 1;
      end
    join_none
    repeat (10) @(negedge aclk);
    check("bp_accepted", 64'(in_hs - base), 64'd8);
    check("bp_s_ready", 64'(s_axis_tready), 64'd0);
    ready_mode = 1;
    n = 0;
    while (!bp_done && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    check("bp_resume_cycles", 64'(n <= 12), 64'd1);
    #1;
    wait_drain();

    // reset mid-packet discards buffered words
    cfg_shift = 5'd0;
    send_beat(64'h0000_0002_0000_0001, 2'b11, 1'b0);
    send_beat(64'h0000_0004_0000_0003, 2'b11, 1'b0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
    check("mid_rst_s_ready", 64'(s_axis_tready), 64'd1);
    repeat (5) @(posedge aclk);
    #1;
    check("mid_rst_no_out", 64'(m_axis_tvalid), 64'd0);
    push_exp(64'h0807060504030201, 8'hFF, 1'b1);
    w = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    send_words(w, 0, 0);
    wait_drain();
    check("post_rst_pkt_count", 64'(pkt_count), 64'd1);

    // randomized packets with random gaps and backpressure
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      w = {};
      n = $urandom_range(1, 18);
      for (int unsigned i = 0; i < n; i++) w.push_back(gen_word());
      sh = $urandom_range(0, 31);
      model_push(w, sh);
      send_words(w, sh, 1);
    end
    wait_drain();
    ready_mode = 1;
    wait_drain();
    check("final_pkt_count", 64'(pkt_count), 64'(model_pkts % 65536));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axis_out_packer.md
Name: axis_out_packer

Overview:
- Sits directly downstream of the accelerator top's m_axis output port.
- Consumes its stream of WORD_WIDTH_ACC accumulator words and requantizes each word to WORD_WIDTH bits using a rounding arithmetic right shift with signed saturation.
- Packs the results into full-width output beats for the DMA write channel.
- Restores packet boundaries from tlast and counts completed packets.

Parameters:
- WORD_WIDTH_ACC, 32, input accumulator word width (signed).
- WORD_WIDTH, 8, output word width (signed).
- S_DATA_WIDTH, 64, input tdata width; S_WORDS = S_DATA_WIDTH/WORD_WIDTH_ACC.
- M_DATA_WIDTH, 64, output tdata width; M_WORDS = M_DATA_WIDTH/WORD_WIDTH. M_WORDS must be an integer multiple of S_WORDS; BEATS = M_WORDS/S_WORDS.
- SHIFT_BITS, 5, width of cfg_shift.
- CNT_BITS, 16, width of pkt_count.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- cfg_shift  in  SHIFT_BITS  right-shift amount, 0..WORD_WIDTH_ACC-1.
- s_axis_tready  out  1  input ready.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tdata  in  S_DATA_WIDTH  accumulator words, word 0 at LSB.
- s_axis_tkeep  in  S_WORDS  one bit per accumulator word.
- m_axis_tready  in  1  output ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tdata  out  M_DATA_WIDTH  packed output words.
- m_axis_tkeep  out  M_WORDS  one bit per output word.
- pkt_count  out  CNT_BITS  number of completed output packets.

Behaviour:
- Interface: one clock aclk; reset aresetn is synchronous, active-low.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, pkt_count=0. All internal valids and the beat index are cleared.
- s_axis_tready is 1 in the cycle after reset deasserts.
- Reset mid-packet discards every buffered word. No partial beat is emitted.
- Input rules:
  - tkeep must be all-ones on non-last beats.
  - On a tlast beat, tkeep must be nonzero and contiguous from the LSB.
  - Any other pattern is undefined.
- Stage Q (quantize register):
  - On each input handshake, each word x is computed in WORD_WIDTH_ACC+1 bits as y = (x + (shift>0 ? 2^(shift-1) : 0)) >>> shift. This is round-half-up.
  - y saturates to [-2^(WORD_WIDTH-1), 2^(WORD_WIDTH-1)-1].
  - Registers q_data, q_keep, q_last and sets q_valid.
- Shift sampling: cfg_shift is sampled on the first input beat of each packet and held until that packet's tlast beat is accepted. Changes to cfg_shift mid-packet are ignored.
- Stage P (pack):
  - An accumulate buffer with beat index idx (0..BEATS-1).
  - completing = (idx==BEATS-1) | q_last.
  - q_adv = q_valid & (~completing | ~m_axis_tvalid | m_axis_tready).
  - On q_adv, the Q words are written at word slot idx*S_WORDS.
  - If not completing: idx increments.
  - If completing:
    - The buffer, with the new words merged, loads the output register.
    - m_axis_tkeep is the OR-accumulated keep bits; unwritten slots are 0 and their data is 0.
    - m_axis_tlast = q_last; m_axis_tvalid is set; idx returns to 0.
- s_axis_tready = ~q_valid | q_adv (combinational). Input and output may both handshake in the same cycle.
- Output register:
  - Held stable while m_axis_tvalid & ~m_axis_tready.
  - Clears m_axis_tvalid on handshake unless reloaded in the same cycle.
- Latency and throughput:
  - Input handshake of the completing beat in cycle t gives m_axis_tvalid=1 in cycle t+2.
  - Sustained throughput is one input beat per cycle when m_axis_tready=1.
- Backpressure: with m_axis_tready=0, the block absorbs (BEATS-1) beats into the buffer plus 1 beat in Q. It then deasserts s_axis_tready. No words are lost or duplicated.
- pkt_count increments on each m_axis handshake with tlast=1 and wraps modulo 2^CNT_BITS.

Optional Feature:
- Macro: OUT_PACKER_RELU_EN.
- When defined: after saturation, negative results are forced to 0 in Stage Q, with no added latency.
- When undefined: signed results pass unchanged and no ReLU logic is synthesized.

Test Plan:
- cfg_shift=4; 4 beats of words 0x10,0x20..0x80, tlast on beat 4 → one beat tdata=0x0807060504030201, tkeep=0xFF, tlast=1, valid exactly 2 cycles after the 4th input handshake; pkt_count=1.
- cfg_shift=0 with words 0x7FFFFFFF and 0x80000000 → bytes 0x7F and 0x80. cfg_shift=4 with words 24 and -24 → bytes 0x02 and 0xFF.
- Packet of 3 beats, last tkeep=2'b01 → output tkeep=0x1F, bytes 5..7 = 0, tlast=1. The next packet starts at slot 0.
- Hold m_axis_tready=0 for 10 cycles during a continuous input stream → s_axis_tready drops after 4 beats past the pending output. Release → 1 beat/cycle, all data in order.
- Assert aresetn=0 after 2 beats of a packet → no output; m_axis_tvalid=0, pkt_count=0. A fresh packet then produces correct output.
- With OUT_PACKER_RELU_EN, cfg_shift=0, input -5 → 0x00 and input 5 → 0x05. Without the macro, -5 → 0xFB.
